// File: rtl/enc_sel_stream_pkg.sv
// rtl/enc_sel_stream_pkg.sv - shared constants, FSM encodings and helpers for the encoder output selector
package enc_sel_stream_pkg;

  localparam int ENC_SYM     = 8;
  localparam int EGF_DIM     = 8;
  localparam int RSC_PAR_LEN = 16;
  localparam int RSC_MES_MAX = 239;

  typedef logic [1:0] sel_stream_state_t;

  localparam sel_stream_state_t ST_IDLE = 2'd0;
  localparam sel_stream_state_t ST_MES  = 2'd1;
  localparam sel_stream_state_t ST_TAIL = 2'd2;
  localparam sel_stream_state_t ST_PAR  = 2'd3;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/enc_sel_stream_lane_mux.sv
// rtl/enc_sel_stream_lane_mux.sv - combinational merge of tail symbols and a parity window into one beat
module enc_sel_lane_mux
  import enc_sel_stream_pkg::*;
#(
  parameter int SYM     = ENC_SYM,
  parameter int DIM     = EGF_DIM,
  parameter int PAR_LEN = RSC_PAR_LEN,
  parameter int CW      = $clog2(SYM + 1),
  parameter int OW      = $clog2(PAR_LEN + SYM + 1)
) (
  input  logic [SYM*DIM-1:0]     tail_data,
  input  logic [CW-1:0]          tail_cnt,
  input  logic                   use_tail,
  input  logic                   par_en,
  input  logic [PAR_LEN*DIM-1:0] par_vec,
  input  logic [OW-1:0]          par_off,
  output logic [SYM*DIM-1:0]     beat_data,
  output logic [CW-1:0]          beat_cnt,
  output logic                   beat_last
);

  int base;
  int tot;

  always_comb begin
    base      = use_tail ? int'(tail_cnt) : 0;
    tot       = base + (par_en ? (PAR_LEN - int'(par_off)) : 0);
    beat_cnt  = CW'(min_int(tot, SYM));
    beat_last = (tot <= SYM);
    beat_data = '0;
    // Parity lanes shift right by the tail length; indices past PAR_LEN stay zero.
    for (int i = 0; i < SYM; i++) begin
      if (i < base) begin
        beat_data[i*DIM +: DIM] = tail_data[i*DIM +: DIM];
      end else if (par_en && ((int'(par_off) + i - base) < PAR_LEN)) begin
        beat_data[i*DIM +: DIM] = par_vec[(int'(par_off) + i - base)*DIM +: DIM];
      end
    end
  end

endmodule

// File: rtl/enc_sel_stream.sv
// rtl/enc_sel_stream.sv - serialises one RS codeword (message then parity) per frame onto a SYM-lane stream
module enc_sel_stream
  import enc_sel_stream_pkg::*;
#(
  parameter int SYM     = ENC_SYM,
  parameter int DIM     = EGF_DIM,
  parameter int MES_MAX = RSC_MES_MAX,
  parameter int PAR_LEN = RSC_PAR_LEN
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(MES_MAX+1)-1:0]   cfg_mes_len,
  input  logic                           cfg_par_en,
  input  logic                           mes_valid,
  output logic                           mes_ready,
  input  logic [SYM*DIM-1:0]             mes_data,
  input  logic                           par_valid,
  output logic                           par_ready,
  input  logic [PAR_LEN*DIM-1:0]         par_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYM*DIM-1:0]             out_data,
  output logic [$clog2(SYM+1)-1:0]       out_cnt,
  output logic                           out_last,
  output logic                           busy
);

  localparam int LW = $clog2(MES_MAX + 1);
  localparam int CW = $clog2(SYM + 1);
  localparam int OW = $clog2(PAR_LEN + SYM + 1);
  localparam int BW = SYM * DIM;

  sel_stream_state_t state_q, state_d;
  logic [LW-1:0]          mes_cnt_q, mes_cnt_d;
  logic [LW-1:0]          f_q, f_d;
  logic [CW-1:0]          r_q, r_d;
  logic                   p_en_q, p_en_d;
  logic [OW-1:0]          off_q, off_d;
  logic [BW-1:0]          tail_q, tail_d;
  logic [PAR_LEN*DIM-1:0] par_q, par_d;
  logic                   par_full_q, par_full_d;
  logic                   out_valid_q, out_valid_d;
  logic [BW-1:0]          out_data_q, out_data_d;
  logic [CW-1:0]          out_cnt_q, out_cnt_d;
  logic                   out_last_q, out_last_d;
  logic                   run_q;

  logic [LW-1:0] l_cfg, f_cfg, f_cur, idx_cur;
  logic [CW-1:0] r_cfg, r_cur;
  logic          p_cur;
  logic          slot_free, mes_fire, par_fire, mux_go;

  logic [BW-1:0] mux_data;
  logic [CW-1:0] mux_cnt;
  logic          mux_last;

  // Length fields are taken from cfg_* only on the first beat; later beats use the latched copy.
  always_comb begin
    l_cfg = cfg_mes_len;
    if ((cfg_mes_len == '0) || (cfg_mes_len > LW'(MES_MAX))) l_cfg = LW'(MES_MAX);
    f_cfg   = l_cfg / LW'(SYM);
    r_cfg   = CW'(l_cfg % LW'(SYM));
    f_cur   = (state_q == ST_IDLE) ? f_cfg : f_q;
    r_cur   = (state_q == ST_IDLE) ? r_cfg : r_q;
    p_cur   = (state_q == ST_IDLE) ? cfg_par_en : p_en_q;
    idx_cur = (state_q == ST_IDLE) ? '0 : mes_cnt_q;
  end

  assign slot_free = !out_valid_q || out_ready;
  assign mes_ready = run_q && slot_free && ((state_q == ST_IDLE) || (state_q == ST_MES));
  assign par_ready = run_q && slot_free && par_valid && !par_full_q &&
                     (((state_q == ST_TAIL) && p_en_q) || (state_q == ST_PAR));
  assign mes_fire  = mes_valid && mes_ready;
  assign par_fire  = par_valid && par_ready;
  assign mux_go    = slot_free && (((state_q == ST_TAIL) && !p_en_q) || par_fire ||
                                   ((state_q == ST_PAR) && par_full_q));

  enc_sel_lane_mux #(
    .SYM     (SYM),
    .DIM     (DIM),
    .PAR_LEN (PAR_LEN),
    .CW      (CW),
    .OW      (OW)
  ) u_lane_mux (
    .tail_data (tail_q),
    .tail_cnt  (r_q),
    .use_tail  (state_q == ST_TAIL),
    .par_en    ((state_q == ST_PAR) || p_en_q),
    .par_vec   (par_full_q ? par_q : par_data),
    .par_off   ((state_q == ST_TAIL) ? OW'(0) : off_q),
    .beat_data (mux_data),
    .beat_cnt  (mux_cnt),
    .beat_last (mux_last)
  );

  always_comb begin
    state_d     = state_q;
    mes_cnt_d   = mes_cnt_q;
    f_d         = f_q;
    r_d         = r_q;
    p_en_d      = p_en_q;
    off_d       = off_q;
    tail_d      = tail_q;
    par_d       = par_q;
    par_full_d  = par_full_q;
    out_valid_d = slot_free ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;

    if (mes_fire) begin
      if (state_q == ST_IDLE) begin
        f_d    = f_cfg;
        r_d    = r_cfg;
        p_en_d = cfg_par_en;
      end
      if (idx_cur == f_cur) begin
        // Partial final beat is parked until parity arrives to fill the remaining lanes.
        tail_d    = mes_data;
        mes_cnt_d = '0;
        state_d   = ST_TAIL;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = mes_data;
        out_cnt_d   = CW'(SYM);
        out_last_d  = 1'b0;
        mes_cnt_d   = idx_cur + LW'(1);
        state_d     = ST_MES;
        if ((idx_cur + LW'(1) == f_cur) && (r_cur == '0)) begin
          mes_cnt_d = '0;
          off_d     = '0;
          if (p_cur) begin
            state_d = ST_PAR;
          end else begin
            out_last_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
    end else if (mux_go) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_cnt_d   = mux_cnt;
      out_last_d  = mux_last;
      if (par_fire) begin
        par_d      = par_data;
        par_full_d = 1'b1;
      end
      off_d = (state_q == ST_TAIL) ? (OW'(SYM) - OW'(r_q)) : (off_q + OW'(SYM));
      if (mux_last) begin
        par_full_d = 1'b0;
        off_d      = '0;
        state_d    = ST_IDLE;
      end else begin
        state_d = ST_PAR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mes_cnt_q   <= '0;
      f_q         <= '0;
      r_q         <= '0;
      p_en_q      <= 1'b0;
      off_q       <= '0;
      tail_q      <= '0;
      par_q       <= '0;
      par_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mes_cnt_q   <= mes_cnt_d;
      f_q         <= f_d;
      r_q         <= r_d;
      p_en_q      <= p_en_d;
      off_q       <= off_d;
      tail_q      <= tail_d;
      par_q       <= par_d;
      par_full_q  <= par_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      run_q       <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/enc_sel_stream.md
Name: enc_sel_stream

Overview:
Parametrised, handshaked successor to the encoder output selector. It serialises one systematic RS codeword per frame onto a SYM-lane output bus. Message symbols come first, then parity; the message tail and the parity head are merged into a single transition beat. Message length is programmable per codeword (shortened codes), and the parity stage can be bypassed. The block sits between the message buffer / parity generator and the encoder output port.

Parameters:
SYM, 8, symbols per beat (lanes), >= 2
DIM, 8, bits per symbol
MES_MAX, 239, maximum message length in symbols
PAR_LEN, 16, parity symbols per codeword, >= 1

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_mes_len  in  $clog2(MES_MAX+1)  message length L; sampled on the first message beat of a codeword
cfg_par_en  in  1  1 = append parity, 0 = message only; sampled with cfg_mes_len
mes_valid  in  1  message beat valid
mes_ready  out  1  message beat accepted
mes_data  in  SYM*DIM  message symbols, lane 0 = earliest; final beat uses lanes 0..r-1 only
par_valid  in  1  parity vector valid
par_ready  out  1  parity vector accepted
par_data  in  PAR_LEN*DIM  parity symbols, index 0 transmitted first
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  SYM*DIM  output symbols; unused lanes are 0
out_cnt  out  $clog2(SYM+1)  number of valid lanes, counted from lane 0
out_last  out  1  final beat of the codeword
busy  out  1  codeword in progress

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: out_valid=0, out_data=0, out_cnt=0, out_last=0, mes_ready=0, par_ready=0, busy=0. State returns to IDLE and all counters clear.
- The output register loads whenever !out_valid || out_ready. out_* are held stable while out_valid && !out_ready.
- Latency: an accepted input beat appears on out_* on the next clock edge.
- Lengths per codeword:
  - L = cfg_mes_len, clamped; 0 or > MES_MAX is treated as MES_MAX.
  - F = L / SYM (number of full message beats); r = L % SYM.
  - P = cfg_par_en ? PAR_LEN : 0.
  - Total output beats = ceil((L+P)/SYM).
- FSM states: IDLE, MES, TAIL, PAR.
- IDLE:
  - mes_ready = output slot free.
  - On the first mes accept, latch L and P and go to MES.
  - The first beat is processed in MES rules, so back-to-back codewords incur no bubble.
- MES:
  - Pass full beats through with out_cnt=SYM; mes beat counter increments on each accept.
  - A beat whose index equals F with r>0 is a tail beat: it is captured into the tail register, nothing is output, and the FSM goes to TAIL.
  - After F full beats with r==0: if P>0, go to PAR at parity offset 0; otherwise the F-th beat carries out_last=1 and the FSM returns to IDLE.
- TAIL:
  - mes_ready=0.
  - P==0: emit tail lanes 0..r-1, out_cnt=r, out_last=1, return to IDLE.
  - P>0: par_ready asserts only when both the parity register is empty and the output slot is free. On par accept, emit the transition beat in the same load:
    - lanes 0..r-1 = tail message symbols;
    - lanes r..SYM-1 = par[0..SYM-r-1];
    - parity offset = SYM-r;
    - out_cnt = min(SYM, r+PAR_LEN); out_last if r+PAR_LEN <= SYM.
- PAR:
  - Entry with r==0 first consumes parity (par_ready as in TAIL); otherwise the parity register is already loaded.
  - Each beat emits par[off..off+SYM-1]; out_cnt = min(SYM, PAR_LEN-off); off += SYM.
  - The beat with off+SYM >= PAR_LEN carries out_last=1, releases the parity register, and the FSM returns to IDLE.
- Late parity: TAIL/PAR stall with out_valid dropping after the pending beat is taken. There is no symbol loss and no reordering.
- Width rules: out_cnt is never 0 while out_valid. Lane indices computed as off+i beyond PAR_LEN output 0, not X.
- Asserting rst_n low mid-codeword discards the partial codeword. Upstream must restart from the codeword's first beat.
- par_valid in IDLE/MES is ignored (par_ready=0). mes_valid in TAIL/PAR is ignored.

Decomposition:
- Add to encoder.vh / the shared package:
  - SEL_STREAM_STATE enum {IDLE, MES, TAIL, PAR};
  - default constants mapped from ENC_SYM, EGF_DIM, RSC_PAR_LEN.
- Sub-module enc_sel_lane_mux: purely combinational merge of tail register, parity register and offset/r into one SYM-lane beat plus out_cnt. It is unit-testable in isolation.
- The top level holds the FSM, counters, tail/parity registers and output register.

Test Plan:
1. SYM=8, PAR=16, L=16, par_en=1, out_ready=1 -> 4 beats: mes0-7, mes8-15, par0-7, par8-15; cnt 8,8,8,8; last on beat 4.
2. L=13, par_en=1 -> beats: mes0-7 | mes8-12+par0-2 (cnt8) | par3-10 (cnt8) | par11-15 (cnt5, last); lanes 5-7 of the last beat are 0.
3. L=13, par_en=1, par_valid delayed 10 cycles after the tail beat -> out_valid low during the wait; transition beat then identical to scenario 2; par_ready high exactly 1 cycle.
4. L=5, par_en=0 -> single beat, cnt5, last=1; par_ready never asserts.
5. Scenario 2 with out_ready toggled 1010... -> out_data/cnt/last stable while stalled; sequence unchanged; mes_ready low whenever the slot is full.
6. rst_n pulsed low after beat 2 of scenario 2, then L=8 codeword -> all outputs 0 during reset; next codeword is mes0-7 then par0-7, par8-15 last, with no residue from the aborted frame.
